// File: rtl/gpio_mmio_port.sv
// gpio_mmio_port
//   Memory-mapped 8-bit GPIO responder sitting on the core's data-memory bus.
//   Four word registers live in a 16-byte window at BASE_ADDR:
//     +0x0 OUT  (RW)  drives gpio_port_out
//     +0x4 IN   (RO)  synchronized pin value
//     +0x8 EDGE (W1C) sticky rising-edge flags
//     +0xC EN   (RW)  interrupt mask for EDGE
//   Ports:
//     clk, reset          system clock, synchronous active-high reset
//     Address, WriteData  byte address / store data from the core
//     MemWrite, MemRead   single-cycle store / load strobes
//     Select              combinational window hit (aligned addresses only)
//     ReadData            registered load data, holds when no load
//     gpio_port_in        asynchronous input pins
//     gpio_port_out       output pins
//     irq                 registered level interrupt, |(EDGE & EN)
module gpio_mmio_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic                  Select,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic [7:0]            gpio_port_in,
  output logic [7:0]            gpio_port_out,
  output logic                  irq
);

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;
  localparam logic [1:0] OFF_EN   = 2'd3;

  logic [7:0]            out_q, out_d;
  logic [7:0]            en_q, en_d;
  logic [7:0]            edge_q, edge_d;
  logic [7:0]            sync1_q, sync1_d;
  logic [7:0]            sync2_q, sync2_d;
  logic [7:0]            prev_q, prev_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic [1:0] offset;
  logic [7:0] reg_rd;
  logic [7:0] rise;
  logic [7:0] clr;
  logic       unused_wdata_hi;

  // Only the low byte of a store is meaningful.
  assign unused_wdata_hi = ^WriteData[DATA_WIDTH-1:8];

  assign offset = Address[3:2];
  assign Select = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);

  always_comb begin
    reg_rd = 8'h00;
    case (offset)
      OFF_OUT:  reg_rd = out_q;
      OFF_IN:   reg_rd = sync2_q;
      OFF_EDGE: reg_rd = edge_q;
      OFF_EN:   reg_rd = en_q;
      default:  reg_rd = 8'h00;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    en_d    = en_q;
    rdata_d = rdata_q;
    clr     = 8'h00;

    sync1_d = gpio_port_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;

    if (MemWrite && Select) begin
      case (offset)
        OFF_OUT:  out_d = WriteData[7:0];
        OFF_EDGE: clr   = WriteData[7:0];
        OFF_EN:   en_d  = WriteData[7:0];
        default:  ;
      endcase
    end

    // A new rise on a bit being cleared in the same cycle keeps the flag set.
    edge_d = (edge_q & ~clr) | rise;
    irq_d  = |(edge_q & en_q);

    // Reads use current register contents, so a simultaneous store returns
    // the pre-write value.
    if (MemRead) begin
      rdata_d = Select ? {{(DATA_WIDTH-8){1'b0}}, reg_rd} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= 8'h00;
      en_q    <= 8'h00;
      edge_q  <= 8'h00;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      prev_q  <= 8'h00;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      en_q    <= en_d;
      edge_q  <= edge_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign gpio_port_out = out_q;
  assign ReadData      = rdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_mmio_port.sv
module tb_gpio_mmio_port;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        Select;
  logic [31:0] ReadData;
  logic [7:0]  gpio_port_in;
  logic [7:0]  gpio_port_out;
  logic        irq;

  always #5 clk = ~clk;

  gpio_mmio_port #(.BASE_ADDR(BASE), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Select(Select), .ReadData(ReadData),
    .gpio_port_in(gpio_port_in), .gpio_port_out(gpio_port_out), .irq(irq)
  );

  // Reference model: register contents plus the pin values the block has
  // sampled at the last three edges (age[0] newest). IN shows the value
  // sampled two edges ago; a rise is a bit that is high at age 1 but was
  // low at age 2.
  logic [7:0]  m_out, m_en, m_edge;
  logic        m_irq;
  logic [7:0]  age [3];
  logic [31:0] exp_q [$];
  bit          rd_due = 0;
  bit          mon_on = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [7:0] model_reg(input logic [1:0] off);
    case (off)
      2'd0: return m_out;
      2'd1: return age[1];
      2'd2: return m_edge;
      default: return m_en;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input logic re, input logic [7:0] pins);
    logic [7:0] clr;
    logic [7:0] rise;
    logic       nirq;
    logic       h;
    reset = rst; Address = a; WriteData = wd; MemWrite = we; MemRead = re;
    gpio_port_in = pins;
    #1;
    check("select", {31'd0, Select}, {31'd0, hit(a)});
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_en = 0; m_edge = 0; m_irq = 0;
      age[0] = 0; age[1] = 0; age[2] = 0;
      exp_q.delete();
      rd_due = 0;
      mon_on = 1;
    end else begin
      h = hit(a);
      if (re) begin
        exp_q.push_back(h ? {24'h0, model_reg(a[3:2])} : 32'h0);
        rd_due = 1;
      end
      rise = age[1] & ~age[2];
      clr  = (we && h && a[3:2] == 2'd2) ? wd[7:0] : 8'h00;
      nirq = |(m_edge & m_en);
      m_edge = (m_edge & ~clr) | rise;
      m_irq  = nirq;
      if (we && h && a[3:2] == 2'd0) m_out = wd[7:0];
      if (we && h && a[3:2] == 2'd3) m_en  = wd[7:0];
      age[2] = age[1]; age[1] = age[0]; age[0] = pins;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] pins);
    step(1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, pins);
  endtask

  // Monitor: compares pins/irq every cycle and pops an expected load value
  // whenever the DUT has just registered a load.
  always @(negedge clk) begin
    if (mon_on) begin
      check("gpio_out", {24'd0, gpio_port_out}, {24'd0, m_out});
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      if (rd_due) begin
        rd_due = 0;
        if (exp_q.size() == 0) begin
          check("rd_queue_empty", 32'd1, 32'd0);
        end else begin
          check("read_data", ReadData, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  pins;
    logic [31:0] a;
    int          sel;

    // reset / defaults
    for (int i = 0; i < 3; i++) step(1'b1, BASE, 32'h0, 1'b0, 1'b0, 8'h00);
    check("rst_out", {24'd0, gpio_port_out}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    step(1'b0, BASE + 32'hC, 32'h0, 1'b0, 1'b1, 8'h00);

    // OUT write / readback / misaligned store
    step(1'b0, BASE, 32'hFFFF_FFA5, 1'b1, 1'b0, 8'h00);
    check("out_a5", {24'd0, gpio_port_out}, 32'hA5);
    step(1'b0, BASE, 32'h0, 1'b0, 1'b1, 8'h00);
    step(1'b0, BASE + 32'h2, 32'h3C, 1'b1, 1'b0, 8'h00);
    check("out_misaligned", {24'd0, gpio_port_out}, 32'hA5);

    // input sync and edge, EN=01
    step(1'b0, BASE + 32'hC, 32'h01, 1'b1, 1'b0, 8'h00);
    idle(8'h81);
    idle(8'h81);
    step(1'b0, BASE + 32'h4, 32'h0, 1'b0, 1'b1, 8'h81);
    step(1'b0, BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h81);
    check("irq_edge", {31'd0, irq}, 32'h1);

    // W1C coinciding with a re-rise of bit 7
    for (int i = 0; i < 3; i++) idle(8'h01);
    idle(8'h81);
    idle(8'h81);
    step(1'b0, BASE + 32'h8, 32'h81, 1'b1, 1'b0, 8'h81);
    step(1'b0, BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'h81);
    check("irq_w1c", {31'd0, irq}, 32'h0);

    // non-hit isolation
    step(1'b0, BASE + 32'h10, 32'h3C, 1'b1, 1'b0, 8'h81);
    step(1'b0, 32'h0, 32'h3C, 1'b1, 1'b0, 8'h81);
    step(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1, 8'h81);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h81);
    check("out_nonhit", {24'd0, gpio_port_out}, 32'hA5);

    // reset in the middle of a store
    step(1'b0, BASE, 32'h5A, 1'b1, 1'b0, 8'h00);
    step(1'b0, BASE + 32'hC, 32'hFF, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) idle(8'h00);
    for (int i = 0; i < 4; i++) idle(8'hFF);
    check("irq_before_rst", {31'd0, irq}, 32'h1);
    step(1'b1, BASE, 32'hFF, 1'b1, 1'b0, 8'hFF);
    check("out_after_rst", {24'd0, gpio_port_out}, 32'h0);
    check("irq_after_rst", {31'd0, irq}, 32'h0);
    step(1'b0, BASE + 32'h8, 32'h0, 1'b0, 1'b1, 8'hFF);

    // randomized traffic
    pins = 8'h00;
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = BASE + {28'd0, 4'($urandom_range(0, 15))};
      else if (sel < 8)  a = BASE + 32'h10;
      else               a = $urandom;
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      step($urandom_range(0, 59) == 0, a, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, pins);
    end

    idle(pins);
    idle(pins);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
